// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: in-order register-file writeback queue with optional reset-time sweep (REGFILE_INIT_EN)
module regfile_wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_addr,
  input  logic [31:0]              in_data,
  output logic                     WE3,
  output logic [4:0]               A3,
  output logic [31:0]              WD3,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [4:0]    q_addr [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic          run, sweep, push, pop;
  logic [4:0]    init_idx;
`ifdef REGFILE_INIT_EN
  typedef enum logic {INIT, RUN} state_t;
  state_t     state, state_n;
  logic [5:0] init_cnt;
  // state register and sweep index; the index stops at 32 to mark the sweep done
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state <= state_n;
      if (sweep) init_cnt <= init_cnt + 6'd1;
    end
  // sweep registers 0..31, then one extra INIT edge hands over to RUN
  always_comb begin
    state_n = state;
    sweep   = 1'b0;
    if (state == INIT) begin
      sweep   = !init_cnt[5];
      state_n = init_cnt[5] ? RUN : INIT;
    end
  end
  assign run      = state == RUN;
  assign init_idx = init_cnt[4:0];
`else
  assign run      = 1'b1;
  assign sweep    = 1'b0;
  assign init_idx = '0;
`endif
  assign in_ready = run && (count < CW'(DEPTH));
  assign push     = in_valid && in_ready && (in_addr != 5'd0);
  assign pop      = run && (count != '0);
  assign busy     = !run || (count != '0) || WE3;
  // queue storage needs no reset: count and pointers define what is valid
  always_ff @(posedge clk)
    if (push) begin
      q_addr[wr_ptr] <= in_addr;
      q_data[wr_ptr] <= in_data;
    end
  // pointers, occupancy and the registered write port
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      WE3    <= 1'b0;
      A3     <= '0;
      WD3    <= '0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      WE3 <= sweep || pop;
      if (sweep) begin
        A3  <= init_idx;
        WD3 <= {27'd0, init_idx};
      end else if (pop) begin
        A3  <= q_addr[rd_ptr];
        WD3 <= q_data[rd_ptr];
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
endmodule
